regctx_seq: RTL and testbench
=============================

# regctx_seq

Register-context save/restore sequencer for the main register file. On SAVE it pushes A, B, C and IX to data memory through a valid/ready memory handshake. On RESTORE it pops four bytes and writes them back through the register file's write port (IN, MRWE, WA1:WA0). It sits between the control unit, the main register file and the data-memory interface. It is used for interrupt entry/exit and subroutine context switches.

## Interface
Parameters: none.

Ports:
- CLK  in  1  system clock, rising-edge
- RESET  in  1  asynchronous, active-low reset
- SAVE  in  1  start save request, sampled in IDLE
- RESTORE  in  1  start restore request, sampled in IDLE
- SP_IN  in  8  stack pointer at request time
- OA, OB, OC, OIX  in  8 each  current register file contents
- MEM_DIN  in  8  memory read data, valid when MEM_RDY=1 on a read
- MEM_RDY  in  1  memory completes current access
- MEM_ADDR  out  8  memory address
- MEM_DOUT  out  8  memory write data
- MEM_WE  out  1  write request, held until accepted
- MEM_RE  out  1  read request, held until accepted
- MR_IN  out  8  to register file IN
- MRWE  out  1  register file write enable
- WA1, WA0  out  1 each  register file write address (00=A, 01=B, 10=C, 11=IX)
- BUSY  out  1  sequence in progress
- DONE  out  1  one-cycle completion pulse
- SP_OUT  out  8  updated stack pointer, valid from DONE until next request

## Operation
- States: IDLE, SAVE_WR, REST_RD, REST_WB, FINISH. A 2-bit beat counter IDX runs 0..3. SP is latched in register SPR.
- IDLE:
  - SAVE=1 → latch SPR=SP_IN, IDX=0, go to SAVE_WR.
  - Else RESTORE=1 → latch SPR=SP_IN, IDX=0, go to REST_RD.
  - SAVE and RESTORE both high → SAVE wins; RESTORE is dropped.
- SAVE_WR:
  - Outputs: MEM_WE=1, MEM_ADDR=SPR−1−IDX, MEM_DOUT = A, B, C, IX for IDX = 0, 1, 2, 3.
  - MEM_RDY=1 at an edge → IDX+1, or go to FINISH after IDX=3.
  - Resulting memory layout: A@SP−1, B@SP−2, C@SP−3, IX@SP−4.
- REST_RD:
  - Outputs: MEM_RE=1, MEM_ADDR=SPR+IDX.
  - MEM_RDY=1 → capture MEM_DIN into DREG, go to REST_WB.
- REST_WB:
  - Exactly one cycle: MRWE=1, MR_IN=DREG, {WA1,WA0}=3−IDX.
  - Pop order: IX@SP, C@SP+1, B@SP+2, A@SP+3.
  - Then IDX+1 → REST_RD, or FINISH after IDX=3.
- FINISH: one cycle with DONE=1. SP_OUT = SPR−4 (save) or SPR+4 (restore). Return to IDLE.
- All address arithmetic is modulo 256; wrap-around is legal (SP_IN=0x02 save → addresses 0x01, 0x00, 0xFF, 0xFE).
- BUSY=1 in every state except IDLE. SAVE/RESTORE are ignored while BUSY.
- MEM_RDY is ignored when neither MEM_WE nor MEM_RE is asserted.
- MEM_WE, MEM_RE and MRWE are mutually exclusive. All three are 0 in IDLE and FINISH.

## Timing
- Reset (RESET=0, asynchronous): state=IDLE, IDX=0, SPR=0, DREG=0.
  - All outputs 0: MEM_ADDR, MEM_DOUT, MEM_WE, MEM_RE, MR_IN, MRWE, WA1, WA0, BUSY, DONE, SP_OUT.
  - Reset mid-sequence aborts immediately. There are no further memory or register writes. Beats already completed are not undone.
- Request sampled at edge N → BUSY and first MEM_WE/MEM_RE visible after edge N.
- Latency with zero-wait memory (MEM_RDY constantly 1):
  - Save: 4 write cycles + FINISH → DONE in the 5th cycle after acceptance.
  - Restore: 4×(RD+WB) + FINISH → DONE in the 9th cycle after acceptance.
- Each wait cycle (MEM_RDY=0) extends the current beat by one cycle. Address and data are held stable.
- A new request may be accepted in the cycle after FINISH.

## Configuration
- REGCTX_SNAPSHOT_EN defined:
  - On SAVE acceptance, OA/OB/OC/OIX are copied into a 32-bit snapshot. MEM_DOUT is sourced from the snapshot.
  - Register changes during the save do not affect the stored image.
- Undefined: MEM_DOUT is sourced live from OA/OB/OC/OIX on each beat. There is no snapshot storage.

## Test plan
- Save, zero-wait: SP_IN=0x80, A/B/C/IX=0x11/0x22/0x33/0x44, SAVE pulse → writes 0x7F=0x11, 0x7E=0x22, 0x7D=0x33, 0x7C=0x44. DONE after 5 cycles, SP_OUT=0x7C.
- Restore with waits: memory 0x7C..0x7F=0x44, 0x33, 0x22, 0x11, SP_IN=0x7C, MEM_RDY low 2 cycles per read → MRWE writes IX=0x44, C=0x33, B=0x22, A=0x11 in that order. SP_OUT=0x80.
- Wrap-around: SP_IN=0x02 save → addresses 0x01, 0x00, 0xFF, 0xFE; SP_OUT=0xFE.
  - Then restore from SP_IN=0xFE → addresses 0xFE, 0xFF, 0x00, 0x01; SP_OUT=0x02.
- Arbitration: SAVE and RESTORE high in the same cycle → only the save sequence runs.
  - RESTORE pulsed while BUSY → ignored, no extra reads.
- Reset mid-op: RESET low during the 2nd save beat → all outputs 0 asynchronously, state IDLE. After release there are no further MEM_WE or DONE pulses.
- Snapshot: with REGCTX_SNAPSHOT_EN, change A to 0x99 after acceptance → memory holds the original 0x11. Without the macro, the beat-0 value reflects the live A.

Source files
------------

// File: rtl/regctx_seq_if.sv
// Bus bundle for the register-context sequencer: control requests, register-file
// read/write ports and the valid/ready data-memory handshake.
interface regctx_seq_if;
  logic       SAVE;
  logic       RESTORE;
  logic [7:0] SP_IN;
  logic [7:0] OA;
  logic [7:0] OB;
  logic [7:0] OC;
  logic [7:0] OIX;
  logic [7:0] MEM_DIN;
  logic       MEM_RDY;
  logic [7:0] MEM_ADDR;
  logic [7:0] MEM_DOUT;
  logic       MEM_WE;
  logic       MEM_RE;
  logic [7:0] MR_IN;
  logic       MRWE;
  logic       WA1;
  logic       WA0;
  logic       BUSY;
  logic       DONE;
  logic [7:0] SP_OUT;

  // Sequencer side
  modport master (
    input  SAVE, RESTORE, SP_IN, OA, OB, OC, OIX, MEM_DIN, MEM_RDY,
    output MEM_ADDR, MEM_DOUT, MEM_WE, MEM_RE, MR_IN, MRWE, WA1, WA0, BUSY, DONE, SP_OUT
  );

  // Control unit / register file / memory side
  modport slave (
    output SAVE, RESTORE, SP_IN, OA, OB, OC, OIX, MEM_DIN, MEM_RDY,
    input  MEM_ADDR, MEM_DOUT, MEM_WE, MEM_RE, MR_IN, MRWE, WA1, WA0, BUSY, DONE, SP_OUT
  );
endinterface

// File: rtl/regctx_seq.sv
// Register-context save/restore sequencer: pushes A,B,C,IX below SP, pops them back.
// Optional REGCTX_SNAPSHOT_EN freezes the register image at save acceptance.
module regctx_seq (
  input  logic         CLK,
  input  logic         RESET,
  regctx_seq_if.master bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SAVE_WR = 3'd1,
    REST_RD = 3'd2,
    REST_WB = 3'd3,
    FINISH  = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] spr_q, spr_d;
  logic [7:0] dreg_q, dreg_d;
  logic [7:0] sp_out_q, sp_out_d;
  logic [7:0] wr_byte;

`ifdef REGCTX_SNAPSHOT_EN
  logic [31:0] snap_q, snap_d;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) snap_q <= '0;
    else        snap_q <= snap_d;
  end

  assign wr_byte = snap_q[8*idx_q +: 8];
`else
  always_comb begin
    case (idx_q)
      2'd0:    wr_byte = bus.OA;
      2'd1:    wr_byte = bus.OB;
      2'd2:    wr_byte = bus.OC;
      default: wr_byte = bus.OIX;
    endcase
  end
`endif

  // NOTE: state registers use non-blocking assignment so every flop samples the
  // pre-edge value of its neighbours, independent of process ordering.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      spr_q    <= 8'd0;
      dreg_q   <= 8'd0;
      sp_out_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      spr_q    <= spr_d;
      dreg_q   <= dreg_d;
      sp_out_q <= sp_out_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    spr_d        = spr_q;
    dreg_d       = dreg_q;
    sp_out_d     = sp_out_q;
`ifdef REGCTX_SNAPSHOT_EN
    snap_d       = snap_q;
`endif
    bus.MEM_ADDR = 8'd0;
    bus.MEM_DOUT = 8'd0;
    bus.MEM_WE   = 1'b0;
    bus.MEM_RE   = 1'b0;
    bus.MR_IN    = 8'd0;
    bus.MRWE     = 1'b0;
    bus.WA1      = 1'b0;
    bus.WA0      = 1'b0;
    bus.DONE     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.SAVE) begin
          spr_d   = bus.SP_IN;
          idx_d   = 2'd0;
          state_d = SAVE_WR;
`ifdef REGCTX_SNAPSHOT_EN
          snap_d  = {bus.OIX, bus.OC, bus.OB, bus.OA};
`endif
        end else if (bus.RESTORE) begin
          spr_d   = bus.SP_IN;
          idx_d   = 2'd0;
          state_d = REST_RD;
        end
      end
      SAVE_WR: begin
        bus.MEM_WE   = 1'b1;
        bus.MEM_ADDR = spr_q - 8'd1 - {6'd0, idx_q};
        bus.MEM_DOUT = wr_byte;
        if (bus.MEM_RDY) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d  = FINISH;
            sp_out_d = spr_q - 8'd4;
          end
        end
      end
      REST_RD: begin
        bus.MEM_RE   = 1'b1;
        bus.MEM_ADDR = spr_q + {6'd0, idx_q};
        if (bus.MEM_RDY) begin
          dreg_d  = bus.MEM_DIN;
          state_d = REST_WB;
        end
      end
      REST_WB: begin
        // Pops come back in reverse push order, so the target is 3-IDX.
        bus.MRWE               = 1'b1;
        bus.MR_IN              = dreg_q;
        {bus.WA1, bus.WA0}     = ~idx_q;
        idx_d                  = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d  = FINISH;
          sp_out_d = spr_q + 8'd4;
        end else begin
          state_d  = REST_RD;
        end
      end
      FINISH: begin
        bus.DONE = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.BUSY   = (state_q != IDLE);
  assign bus.SP_OUT = sp_out_q;

endmodule

// File: tb/tb_regctx_seq.sv
// Self-checking bench for regctx_seq: behavioural memory and register-file model,
// directed and randomized save/restore sequences with random wait states.
module tb_regctx_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  regctx_seq_if bus ();

  regctx_seq dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];
  logic [7:0] rf  [4];          // A, B, C, IX as seen by the sequencer
  logic [7:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];
  logic [7:0] rd_addr_q [$];
  logic [1:0] rw_sel_q  [$];
  logic [7:0] rw_data_q [$];
  int         done_cyc;
  logic [7:0] sp_seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_regs();
    bus.OA  = rf[0];
    bus.OB  = rf[1];
    bus.OC  = rf[2];
    bus.OIX = rf[3];
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mem"}, {bus.MEM_ADDR, bus.MEM_DOUT, bus.MEM_WE, bus.MEM_RE}, 64'd0);
    check({tag, "_rf"},  {bus.MR_IN, bus.MRWE, bus.WA1, bus.WA0}, 64'd0);
    check({tag, "_ctl"}, {bus.BUSY, bus.DONE, bus.SP_OUT}, 64'd0);
  endtask

  // One request plus the memory side of the whole sequence. The bench plays the
  // memory: it decides MEM_RDY at each falling edge and commits the access then.
  task automatic run_seq(input bit s, input bit r, input logic [7:0] sp, input int waits,
                         input int pulse_at, input bit chg_a, input logic [7:0] new_a);
    int   cyc;
    int   wcnt;
    bit   done;
    bit   waiting;
    logic [7:0] held_addr;
    logic [7:0] held_data;
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
    rw_sel_q.delete();  rw_data_q.delete();
    done_cyc = -1;
    sp_seen  = 8'd0;
    drive_regs();
    @(negedge clk);
    bus.SAVE = s; bus.RESTORE = r; bus.SP_IN = sp;
    @(posedge clk);
    #1;
    if (chg_a) begin rf[0] = new_a; bus.OA = new_a; end
    cyc = 0; wcnt = 0; done = 0; waiting = 0;
    held_addr = 8'd0; held_data = 8'd0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      bus.SAVE    = 1'b0;
      bus.RESTORE = (cyc == pulse_at);
      bus.SP_IN   = 8'($urandom);
      check("mutex", 64'((int'(bus.MEM_WE) + int'(bus.MEM_RE) + int'(bus.MRWE)) <= 1), 64'd1);
      if (bus.MRWE) begin
        rw_sel_q.push_back({bus.WA1, bus.WA0});
        rw_data_q.push_back(bus.MR_IN);
      end
      if (bus.DONE) begin
        done = 1; done_cyc = cyc + 1; sp_seen = bus.SP_OUT;
      end
      if (bus.MEM_WE || bus.MEM_RE) begin
        if (waiting) check("hold_stable", {bus.MEM_ADDR, bus.MEM_DOUT}, {held_addr, held_data});
        if (wcnt < waits) begin
          bus.MEM_RDY = 1'b0; wcnt++; waiting = 1;
          held_addr = bus.MEM_ADDR; held_data = bus.MEM_DOUT;
        end else begin
          bus.MEM_RDY = 1'b1; wcnt = 0; waiting = 0;
          if (bus.MEM_WE) begin
            mem[bus.MEM_ADDR] = bus.MEM_DOUT;
            wr_addr_q.push_back(bus.MEM_ADDR);
            wr_data_q.push_back(bus.MEM_DOUT);
          end else begin
            bus.MEM_DIN = mem[bus.MEM_ADDR];
            rd_addr_q.push_back(bus.MEM_ADDR);
          end
        end
      end else begin
        bus.MEM_RDY = 1'($urandom_range(0, 1));
        bus.MEM_DIN = 8'($urandom);
      end
      if (!done) begin @(posedge clk); cyc++; end
    end
    if (!done) check("timeout", 64'd0, 64'd1);
    bus.RESTORE = 1'b0;
    bus.MEM_RDY = 1'b0;
    @(negedge clk);
    check("done_pulse_idle", {bus.DONE, bus.BUSY}, 64'd0);
  endtask

  task automatic verify_save(input string tag, input logic [7:0] sp, input logic [7:0] vals [4],
                             input int waits);
    check({tag, "_nwr"}, wr_addr_q.size(), 4);
    check({tag, "_nrd"}, rd_addr_q.size(), 0);
    check({tag, "_nrw"}, rw_sel_q.size(), 0);
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++)
      check({tag, "_wr"}, {wr_addr_q[i], wr_data_q[i]}, {8'(sp - 8'(1 + i)), vals[i]});
    check({tag, "_sp"}, sp_seen, 8'(sp - 8'd4));
    check({tag, "_lat"}, done_cyc, 5 + 4 * waits);
  endtask

  task automatic verify_restore(input string tag, input logic [7:0] sp, input int waits);
    check({tag, "_nrd"}, rd_addr_q.size(), 4);
    check({tag, "_nwr"}, wr_addr_q.size(), 0);
    check({tag, "_nrw"}, rw_sel_q.size(), 4);
    for (int i = 0; i < 4 && i < rd_addr_q.size(); i++)
      check({tag, "_rd"}, rd_addr_q[i], 8'(sp + 8'(i)));
    for (int i = 0; i < 4 && i < rw_sel_q.size(); i++)
      check({tag, "_rw"}, {rw_sel_q[i], rw_data_q[i]}, {2'(3 - i), mem[8'(sp + 8'(i))]});
    check({tag, "_sp"}, sp_seen, 8'(sp + 8'd4));
    check({tag, "_lat"}, done_cyc, 9 + 4 * waits);
  endtask

  initial begin
    logic [7:0] vals [4];
    logic [7:0] sp;
    int         w;
    int         we_cnt;
    int         done_cnt;
    bit         is_save;

    bus.SAVE = 0; bus.RESTORE = 0; bus.SP_IN = 0; bus.MEM_DIN = 0; bus.MEM_RDY = 0;
    rf = '{8'h11, 8'h22, 8'h33, 8'h44};
    drive_regs();
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);

    #12;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait save from 0x80
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_seq(1, 0, 8'h80, 0, -1, 0, 8'h00);
    verify_save("save80", 8'h80, vals, 0);

    // Restore from 0x7C with two wait cycles per read
    mem[8'h7C] = 8'h44; mem[8'h7D] = 8'h33; mem[8'h7E] = 8'h22; mem[8'h7F] = 8'h11;
    run_seq(0, 1, 8'h7C, 2, -1, 0, 8'h00);
    verify_restore("rest7c", 8'h7C, 2);
    check("rest7c_ix_first", rw_data_q.size() > 0 ? {rw_sel_q[0], rw_data_q[0]} : 10'h0, {2'd3, 8'h44});

    // Wrap-around save from 0x02 then restore from 0xFE
    for (int i = 0; i < 4; i++) rf[i] = 8'($urandom);
    vals = rf;
    run_seq(1, 0, 8'h02, 1, -1, 0, 8'h00);
    verify_save("wrap_save", 8'h02, vals, 1);
    run_seq(0, 1, 8'hFE, 0, -1, 0, 8'h00);
    verify_restore("wrap_rest", 8'hFE, 0);
    for (int i = 0; i < 4 && i < rw_data_q.size(); i++)
      check("wrap_roundtrip", rw_data_q[i], vals[3 - i]);

    // SAVE and RESTORE together, then a RESTORE pulse mid-save
    vals = rf;
    run_seq(1, 1, 8'h60, 0, -1, 0, 8'h00);
    verify_save("arb_both", 8'h60, vals, 0);
    run_seq(1, 0, 8'hA0, 1, 2, 0, 8'h00);
    verify_save("arb_busy", 8'hA0, vals, 1);

    // Randomized mix
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 4; i++) rf[i] = 8'($urandom);
      vals    = rf;
      sp      = 8'($urandom);
      w       = $urandom_range(0, 3);
      is_save = 1'($urandom_range(0, 1));
      if (is_save) begin
        run_seq(1, 1'($urandom_range(0, 1)), sp, w, -1, 0, 8'h00);
        verify_save("rnd_save", sp, vals, w);
      end else begin
        for (int i = 0; i < 4; i++) mem[8'(sp + 8'(i))] = 8'($urandom);
        run_seq(0, 1, sp, w, -1, 0, 8'h00);
        verify_restore("rnd_rest", sp, w);
      end
    end

    // A changes right after acceptance
    rf = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_seq(1, 0, 8'h80, 0, -1, 1, 8'h99);
`ifdef REGCTX_SNAPSHOT_EN
    check("snap_a", mem[8'h7F], 8'h11);
`else
    check("live_a", mem[8'h7F], 8'h99);
`endif

    // Reset during the second save beat
    rf = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    drive_regs();
    mem[8'h3F] = 8'h00;
    @(negedge clk);
    bus.SAVE = 1; bus.SP_IN = 8'h40;
    @(posedge clk);
    @(negedge clk);
    bus.SAVE = 0; bus.MEM_RDY = 1;
    if (bus.MEM_WE) mem[bus.MEM_ADDR] = bus.MEM_DOUT;
    @(posedge clk);
    #2;
    check("mid_beat2_we", {bus.MEM_WE, bus.MEM_ADDR}, {1'b1, 8'h3E});
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    we_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.MEM_WE) we_cnt++;
      if (bus.DONE)   done_cnt++;
    end
    check("post_reset_we", we_cnt, 0);
    check("post_reset_done", done_cnt, 0);
    check("post_reset_beat0_kept", mem[8'h3F], 8'hA1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
